// File: rtl/register_rename_unit_if.sv
// Rename/commit bus between the decode stage (master) and register_rename_unit (slave).
// Optional busy-table signals exist only when RENAME_BUSY_TABLE_EN is defined.
interface register_rename_unit_if #(
   parameter int unsigned ARCH_REGS    = 32,
   parameter int unsigned PHYS_REGS    = 64,
   parameter int unsigned RENAME_WIDTH = 2
);
   localparam int unsigned ARCH_W = $clog2(ARCH_REGS);
   localparam int unsigned PHYS_W = $clog2(PHYS_REGS);

   logic [RENAME_WIDTH-1:0]        rn_valid;
   logic [RENAME_WIDTH-1:0]        rn_uses_rs;
   logic [RENAME_WIDTH-1:0]        rn_uses_rt;
   logic [RENAME_WIDTH-1:0]        rn_uses_rw;
   logic [RENAME_WIDTH*ARCH_W-1:0] rn_rs_arch;
   logic [RENAME_WIDTH*ARCH_W-1:0] rn_rt_arch;
   logic [RENAME_WIDTH*ARCH_W-1:0] rn_rw_arch;
   logic                           rn_ready;
   logic [RENAME_WIDTH*PHYS_W-1:0] rn_rs_phys;
   logic [RENAME_WIDTH*PHYS_W-1:0] rn_rt_phys;
   logic [RENAME_WIDTH*PHYS_W-1:0] rn_rw_phys;
   logic [RENAME_WIDTH*PHYS_W-1:0] rn_rw_old_phys;
   logic [RENAME_WIDTH-1:0]        cm_valid;
   logic [RENAME_WIDTH*ARCH_W-1:0] cm_rw_arch;
   logic [RENAME_WIDTH*PHYS_W-1:0] cm_rw_phys;
   logic [RENAME_WIDTH*PHYS_W-1:0] cm_old_phys;
   logic                           flush;
   logic [PHYS_W:0]                free_count;
`ifdef RENAME_BUSY_TABLE_EN
   logic [RENAME_WIDTH-1:0]        wb_valid;
   logic [RENAME_WIDTH*PHYS_W-1:0] wb_phys;
   logic [RENAME_WIDTH-1:0]        rn_rs_busy;
   logic [RENAME_WIDTH-1:0]        rn_rt_busy;

   modport master (
      output rn_valid, rn_uses_rs, rn_uses_rt, rn_uses_rw,
      output rn_rs_arch, rn_rt_arch, rn_rw_arch,
      input  rn_ready, rn_rs_phys, rn_rt_phys, rn_rw_phys, rn_rw_old_phys,
      output cm_valid, cm_rw_arch, cm_rw_phys, cm_old_phys, flush,
      input  free_count,
      output wb_valid, wb_phys,
      input  rn_rs_busy, rn_rt_busy
   );
   modport slave (
      input  rn_valid, rn_uses_rs, rn_uses_rt, rn_uses_rw,
      input  rn_rs_arch, rn_rt_arch, rn_rw_arch,
      output rn_ready, rn_rs_phys, rn_rt_phys, rn_rw_phys, rn_rw_old_phys,
      input  cm_valid, cm_rw_arch, cm_rw_phys, cm_old_phys, flush,
      output free_count,
      input  wb_valid, wb_phys,
      output rn_rs_busy, rn_rt_busy
   );
`else
   modport master (
      output rn_valid, rn_uses_rs, rn_uses_rt, rn_uses_rw,
      output rn_rs_arch, rn_rt_arch, rn_rw_arch,
      input  rn_ready, rn_rs_phys, rn_rt_phys, rn_rw_phys, rn_rw_old_phys,
      output cm_valid, cm_rw_arch, cm_rw_phys, cm_old_phys, flush,
      input  free_count
   );
   modport slave (
      input  rn_valid, rn_uses_rs, rn_uses_rt, rn_uses_rw,
      input  rn_rs_arch, rn_rt_arch, rn_rw_arch,
      output rn_ready, rn_rs_phys, rn_rt_phys, rn_rw_phys, rn_rw_old_phys,
      input  cm_valid, cm_rw_arch, cm_rw_phys, cm_old_phys, flush,
      output free_count
   );
`endif
endinterface

// File: rtl/register_rename_unit.sv
// Multi-channel register rename unit: speculative map, committed map and a
// circular free list. Renames up to RENAME_WIDTH instructions per cycle, frees
// old mappings at in-order commit, recovers from flush in one cycle.
// Optional busy table: define RENAME_BUSY_TABLE_EN.
module register_rename_unit #(
   parameter int unsigned ARCH_REGS    = 32,
   parameter int unsigned PHYS_REGS    = 64,
   parameter int unsigned RENAME_WIDTH = 2
) (
   input logic                  clk,
   input logic                  rst_n,
   register_rename_unit_if.slave bus
);
   localparam int unsigned ARCH_W     = $clog2(ARCH_REGS);
   localparam int unsigned PHYS_W     = $clog2(PHYS_REGS);
   localparam int unsigned FREE_DEPTH = PHYS_REGS - ARCH_REGS;
   localparam int unsigned IDX_W      = (FREE_DEPTH > 1) ? $clog2(FREE_DEPTH) : 1;
   localparam int unsigned PTR_W      = PHYS_W + 1;
   localparam int unsigned CNT_W      = PHYS_W + 1;

   typedef logic [ARCH_W-1:0] arch_t;
   typedef logic [PHYS_W-1:0] phys_t;
   typedef logic [PTR_W-1:0]  ptr_t;
   typedef logic [CNT_W-1:0]  cnt_t;

   localparam cnt_t  CNT_ONE    = CNT_W'(1);
   localparam cnt_t  CNT_FULL   = CNT_W'(FREE_DEPTH);
   localparam phys_t IDX_LAST   = PHYS_W'(FREE_DEPTH - 1);
   localparam phys_t IDX_ONE    = PHYS_W'(1);
   localparam ptr_t  WR_PTR_RST = {1'b1, {PHYS_W{1'b0}}};

   // Pointer = {wrap, index}; index runs modulo FREE_DEPTH, wrap toggles on rollover.
   function automatic ptr_t ptr_inc(input ptr_t p);
      if (p[PHYS_W-1:0] == IDX_LAST) return {~p[PHYS_W], {PHYS_W{1'b0}}};
      return {p[PHYS_W], p[PHYS_W-1:0] + IDX_ONE};
   endfunction

   phys_t spec_map_q   [ARCH_REGS];
   phys_t spec_map_d   [ARCH_REGS];
   phys_t commit_map_q [ARCH_REGS];
   phys_t commit_map_d [ARCH_REGS];
   phys_t free_mem_q   [FREE_DEPTH];
   ptr_t  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_adv;
   cnt_t  free_count_q, free_count_d;

   arch_t rs_arch [RENAME_WIDTH];
   arch_t rt_arch [RENAME_WIDTH];
   arch_t rw_arch [RENAME_WIDTH];
   arch_t cm_arch [RENAME_WIDTH];
   phys_t cm_phys [RENAME_WIDTH];
   phys_t cm_old  [RENAME_WIDTH];

   logic [RENAME_WIDTH-1:0] alloc;
   logic [RENAME_WIDTH-1:0] commit_en;
   phys_t new_phys    [RENAME_WIDTH];
   phys_t rs_phys     [RENAME_WIDTH];
   phys_t rt_phys     [RENAME_WIDTH];
   phys_t rw_old_phys [RENAME_WIDTH];
   ptr_t  push_ptr    [RENAME_WIDTH];
   cnt_t  need, freed;
   logic  ready, fire;

   // Unpack the flat per-channel buses
   always_comb begin
      for (int unsigned k = 0; k < RENAME_WIDTH; k++) begin
         rs_arch[k] = bus.rn_rs_arch[k*ARCH_W +: ARCH_W];
         rt_arch[k] = bus.rn_rt_arch[k*ARCH_W +: ARCH_W];
         rw_arch[k] = bus.rn_rw_arch[k*ARCH_W +: ARCH_W];
         cm_arch[k] = bus.cm_rw_arch[k*ARCH_W +: ARCH_W];
         cm_phys[k] = bus.cm_rw_phys[k*PHYS_W +: PHYS_W];
         cm_old[k]  = bus.cm_old_phys[k*PHYS_W +: PHYS_W];
      end
   end

   // Allocation: each allocating channel takes the next free-list slot in order
   always_comb begin
      ptr_t p;
      p    = rd_ptr_q;
      need = '0;
      for (int unsigned k = 0; k < RENAME_WIDTH; k++) begin
         alloc[k]    = bus.rn_valid[k] & bus.rn_uses_rw[k] & (rw_arch[k] != '0);
         new_phys[k] = '0;
         if (alloc[k]) begin
            new_phys[k] = free_mem_q[p[IDX_W-1:0]];
            p           = ptr_inc(p);
            need        = need + CNT_ONE;
         end
      end
      rd_adv = p;
   end

   assign ready = ~bus.flush & (need <= free_count_q);
   assign fire  = ready & (|bus.rn_valid);

   // Source and old-destination lookup with intra-group bypass (youngest earlier writer wins)
   always_comb begin
      for (int unsigned k = 0; k < RENAME_WIDTH; k++) begin
         rs_phys[k]     = '0;
         rt_phys[k]     = '0;
         rw_old_phys[k] = '0;
         if (bus.rn_uses_rs[k] && rs_arch[k] != '0) rs_phys[k] = spec_map_q[rs_arch[k]];
         if (bus.rn_uses_rt[k] && rt_arch[k] != '0) rt_phys[k] = spec_map_q[rt_arch[k]];
         if (bus.rn_uses_rw[k] && rw_arch[k] != '0) rw_old_phys[k] = spec_map_q[rw_arch[k]];
         for (int unsigned j = 0; j < RENAME_WIDTH; j++) begin
            if (j < k && alloc[j]) begin
               if (bus.rn_uses_rs[k] && rs_arch[k] == rw_arch[j]) rs_phys[k] = new_phys[j];
               if (bus.rn_uses_rt[k] && rt_arch[k] == rw_arch[j]) rt_phys[k] = new_phys[j];
               if (bus.rn_uses_rw[k] && rw_arch[k] == rw_arch[j]) rw_old_phys[k] = new_phys[j];
            end
         end
      end
   end

   // Commit: update committed map and compute push slots in channel order
   always_comb begin
      ptr_t p;
      p            = wr_ptr_q;
      freed        = '0;
      commit_map_d = commit_map_q;
      for (int unsigned k = 0; k < RENAME_WIDTH; k++) begin
         commit_en[k] = bus.cm_valid[k] & (cm_arch[k] != '0);
         push_ptr[k]  = p;
         if (commit_en[k]) begin
            commit_map_d[cm_arch[k]] = cm_phys[k];
            p     = ptr_inc(p);
            freed = freed + CNT_ONE;
         end
      end
      wr_ptr_d = p;
   end

   // Next state: flush restores the committed view and rewinds the free list to full
   always_comb begin
      spec_map_d   = spec_map_q;
      rd_ptr_d     = rd_ptr_q;
      free_count_d = free_count_q + freed;
      if (bus.flush) begin
         spec_map_d   = commit_map_d;
         rd_ptr_d     = {~wr_ptr_d[PTR_W-1], wr_ptr_d[PTR_W-2:0]};
         free_count_d = CNT_FULL;
      end else if (fire) begin
         for (int unsigned k = 0; k < RENAME_WIDTH; k++) begin
            if (alloc[k]) spec_map_d[rw_arch[k]] = new_phys[k];
         end
         rd_ptr_d     = rd_adv;
         free_count_d = free_count_q - need + freed;
      end
   end

   // Map tables, pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < ARCH_REGS; i++) begin
            spec_map_q[i]   <= PHYS_W'(i);
            commit_map_q[i] <= PHYS_W'(i);
         end
         rd_ptr_q     <= '0;
         wr_ptr_q     <= WR_PTR_RST;
         free_count_q <= CNT_FULL;
      end else begin
         spec_map_q   <= spec_map_d;
         commit_map_q <= commit_map_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         free_count_q <= free_count_d;
      end
   end

   // Free-list storage: committed old mappings are written at the push slots
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < FREE_DEPTH; i++) free_mem_q[i] <= PHYS_W'(ARCH_REGS + i);
      end else begin
         for (int unsigned k = 0; k < RENAME_WIDTH; k++) begin
            if (commit_en[k]) free_mem_q[push_ptr[k][IDX_W-1:0]] <= cm_old[k];
         end
      end
   end

   // Pack per-channel results onto the bus
   always_comb begin
      bus.rn_rs_phys     = '0;
      bus.rn_rt_phys     = '0;
      bus.rn_rw_phys     = '0;
      bus.rn_rw_old_phys = '0;
      for (int unsigned k = 0; k < RENAME_WIDTH; k++) begin
         bus.rn_rs_phys[k*PHYS_W +: PHYS_W]     = rs_phys[k];
         bus.rn_rt_phys[k*PHYS_W +: PHYS_W]     = rt_phys[k];
         bus.rn_rw_phys[k*PHYS_W +: PHYS_W]     = new_phys[k];
         bus.rn_rw_old_phys[k*PHYS_W +: PHYS_W] = rw_old_phys[k];
      end
   end

   assign bus.rn_ready   = ready;
   assign bus.free_count = free_count_q;

`ifdef RENAME_BUSY_TABLE_EN
   logic [PHYS_REGS-1:0] busy_q, busy_d;
   phys_t wb_phys [RENAME_WIDTH];

   // Busy lookup: bypassed sources are busy; same-cycle writeback reads as ready.
   // A bypassed phys is a freshly allocated one, so matching new_phys identifies it.
   always_comb begin
      bus.rn_rs_busy = '0;
      bus.rn_rt_busy = '0;
      for (int unsigned k = 0; k < RENAME_WIDTH; k++) begin
         wb_phys[k] = bus.wb_phys[k*PHYS_W +: PHYS_W];
      end
      for (int unsigned k = 0; k < RENAME_WIDTH; k++) begin
         logic rs_b, rt_b, rs_byp, rt_byp;
         rs_b   = busy_q[rs_phys[k]] & (rs_phys[k] != '0);
         rt_b   = busy_q[rt_phys[k]] & (rt_phys[k] != '0);
         rs_byp = 1'b0;
         rt_byp = 1'b0;
         for (int unsigned j = 0; j < RENAME_WIDTH; j++) begin
            if (bus.wb_valid[j] && wb_phys[j] == rs_phys[k]) rs_b = 1'b0;
            if (bus.wb_valid[j] && wb_phys[j] == rt_phys[k]) rt_b = 1'b0;
            if (j < k && alloc[j] && new_phys[j] == rs_phys[k]) rs_byp = 1'b1;
            if (j < k && alloc[j] && new_phys[j] == rt_phys[k]) rt_byp = 1'b1;
         end
         bus.rn_rs_busy[k] = (rs_phys[k] != '0) & (rs_byp | rs_b);
         bus.rn_rt_busy[k] = (rt_phys[k] != '0) & (rt_byp | rt_b);
      end
   end

   // Busy next state: writebacks clear, fired allocations set, flush clears all
   always_comb begin
      busy_d = busy_q;
      for (int unsigned k = 0; k < RENAME_WIDTH; k++) begin
         if (bus.wb_valid[k]) busy_d[wb_phys[k]] = 1'b0;
      end
      if (fire) begin
         for (int unsigned k = 0; k < RENAME_WIDTH; k++) begin
            if (alloc[k]) busy_d[new_phys[k]] = 1'b1;
         end
      end
      if (bus.flush) busy_d = '0;
      busy_d[0] = 1'b0;
   end

   // Busy table register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end
`endif
endmodule

// File: tb/tb_register_rename_unit.sv
// Self-checking bench for register_rename_unit: directed scenarios followed by
// randomized rename/commit/flush traffic checked against a sequential-rename
// reference model (maps as arrays, free list and in-flight writes as queues).
module tb_register_rename_unit;
   localparam int unsigned ARCH_REGS  = 32;
   localparam int unsigned PHYS_REGS  = 64;
   localparam int unsigned RW         = 2;
   localparam int unsigned ARCH_W     = 5;
   localparam int unsigned PHYS_W     = 6;
   localparam int unsigned FREE_DEPTH = PHYS_REGS - ARCH_REGS;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   register_rename_unit_if #(.ARCH_REGS(ARCH_REGS), .PHYS_REGS(PHYS_REGS), .RENAME_WIDTH(RW)) ifc ();
   register_rename_unit #(.ARCH_REGS(ARCH_REGS), .PHYS_REGS(PHYS_REGS), .RENAME_WIDTH(RW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // stimulus
   bit [RW-1:0] s_valid, s_urs, s_urt, s_urw, c_valid;
   int s_rs [RW];
   int s_rt [RW];
   int s_rw [RW];
   int c_arch [RW];
   int c_phys [RW];
   int c_old  [RW];
   bit s_flush;

   // reference model
   int m_spec   [ARCH_REGS];
   int m_commit [ARCH_REGS];
   int m_free [$];
   int rob_arch [$];
   int rob_new  [$];
   int rob_old  [$];
   bit exp_ready;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] field(input logic [RW*PHYS_W-1:0] v, input int unsigned k);
      return 32'(v[k*PHYS_W +: PHYS_W]);
   endfunction

   task automatic clear_stim();
      s_valid = '0; s_urs = '0; s_urt = '0; s_urw = '0; c_valid = '0; s_flush = 1'b0;
      for (int k = 0; k < RW; k++) begin
         s_rs[k] = 0; s_rt[k] = 0; s_rw[k] = 0;
         c_arch[k] = 0; c_phys[k] = 0; c_old[k] = 0;
      end
   endtask

   task automatic drive();
      ifc.rn_valid   = s_valid;
      ifc.rn_uses_rs = s_urs;
      ifc.rn_uses_rt = s_urt;
      ifc.rn_uses_rw = s_urw;
      ifc.cm_valid   = c_valid;
      ifc.flush      = s_flush;
      for (int k = 0; k < RW; k++) begin
         ifc.rn_rs_arch[k*ARCH_W +: ARCH_W]  = ARCH_W'(s_rs[k]);
         ifc.rn_rt_arch[k*ARCH_W +: ARCH_W]  = ARCH_W'(s_rt[k]);
         ifc.rn_rw_arch[k*ARCH_W +: ARCH_W]  = ARCH_W'(s_rw[k]);
         ifc.cm_rw_arch[k*ARCH_W +: ARCH_W]  = ARCH_W'(c_arch[k]);
         ifc.cm_rw_phys[k*PHYS_W +: PHYS_W]  = PHYS_W'(c_phys[k]);
         ifc.cm_old_phys[k*PHYS_W +: PHYS_W] = PHYS_W'(c_old[k]);
      end
`ifdef RENAME_BUSY_TABLE_EN
      ifc.wb_valid = '0;
      ifc.wb_phys  = '0;
`endif
   endtask

   task automatic model_reset();
      m_free.delete(); rob_arch.delete(); rob_new.delete(); rob_old.delete();
      for (int i = 0; i < ARCH_REGS; i++) begin
         m_spec[i] = i;
         m_commit[i] = i;
      end
      for (int i = ARCH_REGS; i < PHYS_REGS; i++) m_free.push_back(i);
   endtask

   // Drive at negedge, then compare every output with a sequential rename of the group
   task automatic drive_and_check();
      int tmp [ARCH_REGS];
      int n, e;
      @(negedge clk);
      drive();
      #1;
      tmp = m_spec;
      n = 0;
      check_eq("free_count", 32'(ifc.free_count), m_free.size());
      for (int k = 0; k < RW; k++) begin
         e = s_urs[k] ? ((s_rs[k] == 0) ? 0 : tmp[s_rs[k]]) : 0;
         if (e >= 0) check_eq($sformatf("rs_phys%0d", k), field(ifc.rn_rs_phys, k), e);
         e = s_urt[k] ? ((s_rt[k] == 0) ? 0 : tmp[s_rt[k]]) : 0;
         if (e >= 0) check_eq($sformatf("rt_phys%0d", k), field(ifc.rn_rt_phys, k), e);
         e = s_urw[k] ? ((s_rw[k] == 0) ? 0 : tmp[s_rw[k]]) : 0;
         if (e >= 0) check_eq($sformatf("rw_old_phys%0d", k), field(ifc.rn_rw_old_phys, k), e);
         if (s_valid[k] && s_urw[k] && s_rw[k] != 0) begin
            if (n < m_free.size()) begin
               e = m_free[n];
               check_eq($sformatf("rw_phys%0d", k), field(ifc.rn_rw_phys, k), e);
            end else begin
               e = -1;
            end
            tmp[s_rw[k]] = e;
            n++;
         end else begin
            check_eq($sformatf("rw_phys%0d_zero", k), field(ifc.rn_rw_phys, k), 0);
         end
      end
      exp_ready = !s_flush && (n <= m_free.size());
      check_eq("rn_ready", 32'(ifc.rn_ready), 32'(exp_ready));
   endtask

   // Apply the clock edge to the model: commits, then flush or fire
   task automatic advance();
      bit fire;
      int p;
      fire = exp_ready && (s_valid != '0);
      @(posedge clk);
      for (int k = 0; k < RW; k++) begin
         if (c_valid[k] && c_arch[k] != 0) begin
            m_commit[c_arch[k]] = c_phys[k];
            m_free.push_back(c_old[k]);
            if (rob_new.size() > 0) begin
               void'(rob_arch.pop_front()); void'(rob_new.pop_front()); void'(rob_old.pop_front());
            end
         end
      end
      if (s_flush) begin
         m_spec = m_commit;
         for (int i = rob_new.size() - 1; i >= 0; i--) m_free.push_front(rob_new[i]);
         rob_arch.delete(); rob_new.delete(); rob_old.delete();
      end else if (fire) begin
         for (int k = 0; k < RW; k++) begin
            if (s_valid[k] && s_urw[k] && s_rw[k] != 0) begin
               p = m_free.pop_front();
               rob_arch.push_back(s_rw[k]);
               rob_new.push_back(p);
               rob_old.push_back(m_spec[s_rw[k]]);
               m_spec[s_rw[k]] = p;
            end
         end
      end
   endtask

   task automatic cycle();
      drive_and_check();
      advance();
   endtask

   // Asynchronous reset at an arbitrary point; checks identity maps while held
   task automatic reset_dut();
      @(negedge clk);
      #2;
      clear_stim();
      drive();
      rst_n = 1'b0;
      model_reset();
      exp_ready = 1'b1;
      #1;
      check_eq("rst_free_count", 32'(ifc.free_count), FREE_DEPTH);
      check_eq("rst_ready", 32'(ifc.rn_ready), 1);
      for (int i = 0; i < ARCH_REGS; i += RW) begin
         for (int k = 0; k < RW; k++) begin
            s_urs[k] = 1'b1;
            s_rs[k]  = i + k;
         end
         drive();
         #1;
         for (int k = 0; k < RW; k++) check_eq("rst_identity", field(ifc.rn_rs_phys, k), i + k);
      end
      clear_stim();
      drive();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic commit_rob_front(input int ch, input int old_override);
      c_valid[ch] = 1'b1;
      c_arch[ch]  = rob_arch[ch];
      c_phys[ch]  = rob_new[ch];
      c_old[ch]   = (old_override >= 0) ? old_override : rob_old[ch];
   endtask

   initial begin
      #(1000000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int nc, lim;
      clear_stim();
      drive();
      model_reset();
      #1 rst_n = 1'b0;
      #2;
      check_eq("init_free_count", 32'(ifc.free_count), FREE_DEPTH);
      check_eq("init_ready", 32'(ifc.rn_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;

      // single rename: rw=5, rs=5
      clear_stim();
      s_valid[0] = 1; s_urs[0] = 1; s_rs[0] = 5; s_urw[0] = 1; s_rw[0] = 5;
      drive_and_check();
      check_eq("t1_rs", field(ifc.rn_rs_phys, 0), 5);
      check_eq("t1_rw", field(ifc.rn_rw_phys, 0), 32);
      check_eq("t1_old", field(ifc.rn_rw_old_phys, 0), 5);
      advance();
      clear_stim();
      drive_and_check();
      check_eq("t1_free_count", 32'(ifc.free_count), 31);
      advance();

      // intra-group bypass
      reset_dut();
      clear_stim();
      s_valid = 2'b11; s_urw = 2'b11; s_rw[0] = 3; s_rw[1] = 3; s_urs[1] = 1; s_rs[1] = 3;
      drive_and_check();
      check_eq("t2_rw0", field(ifc.rn_rw_phys, 0), 32);
      check_eq("t2_rs1", field(ifc.rn_rs_phys, 1), 32);
      check_eq("t2_old1", field(ifc.rn_rw_old_phys, 1), 32);
      check_eq("t2_rw1", field(ifc.rn_rw_phys, 1), 33);
      advance();
      clear_stim();
      s_urs[0] = 1; s_rs[0] = 3;
      drive_and_check();
      check_eq("t2_map3", field(ifc.rn_rs_phys, 0), 33);
      advance();

      // drain the free list, stall, then recycle a committed register
      reset_dut();
      for (int c = 0; c < 16; c++) begin
         clear_stim();
         s_valid = 2'b11; s_urw = 2'b11;
         s_rw[0] = (2*c) % 31 + 1; s_rw[1] = (2*c + 1) % 31 + 1;
         cycle();
      end
      clear_stim();
      s_valid = 2'b11; s_urw = 2'b11; s_rw[0] = 10; s_rw[1] = 11;
      commit_rob_front(0, 7);
      drive_and_check();
      check_eq("t3_stall", 32'(ifc.rn_ready), 0);
      advance();
      clear_stim();
      s_valid[0] = 1; s_urw[0] = 1; s_rw[0] = 9;
      drive_and_check();
      check_eq("t3_free_count", 32'(ifc.free_count), 1);
      check_eq("t3_ready", 32'(ifc.rn_ready), 1);
      check_eq("t3_recycled", field(ifc.rn_rw_phys, 0), 7);
      advance();

      // flush after partial commit
      reset_dut();
      clear_stim(); s_valid[0] = 1; s_urw[0] = 1; s_rw[0] = 4; cycle();
      clear_stim(); s_valid[0] = 1; s_urw[0] = 1; s_rw[0] = 4; cycle();
      clear_stim(); commit_rob_front(0, -1); cycle();
      clear_stim(); s_flush = 1; s_valid[0] = 1; s_urw[0] = 1; s_rw[0] = 6;
      drive_and_check();
      check_eq("t4_flush_blocks", 32'(ifc.rn_ready), 0);
      advance();
      clear_stim(); s_valid[0] = 1; s_urs[0] = 1; s_rs[0] = 4; s_urw[0] = 1; s_rw[0] = 4;
      drive_and_check();
      check_eq("t4_map4", field(ifc.rn_rs_phys, 0), 32);
      check_eq("t4_free_count", 32'(ifc.free_count), 32);
      check_eq("t4_resume", field(ifc.rn_rw_phys, 0), 33);
      advance();

      // arch 0 writes and commits
      reset_dut();
      clear_stim(); s_valid[0] = 1; s_urw[0] = 1; s_rw[0] = 0;
      drive_and_check();
      check_eq("t5_rw0", field(ifc.rn_rw_phys, 0), 0);
      check_eq("t5_old0", field(ifc.rn_rw_old_phys, 0), 0);
      advance();
      clear_stim(); c_valid[0] = 1; c_arch[0] = 0; c_phys[0] = 0; c_old[0] = 9;
      drive_and_check();
      check_eq("t5_fc_a", 32'(ifc.free_count), 32);
      advance();
      clear_stim();
      drive_and_check();
      check_eq("t5_fc_b", 32'(ifc.free_count), 32);
      advance();

      // mid-stream reset with outstanding allocations
      for (int c = 0; c < 5; c++) begin
         clear_stim();
         s_valid = 2'b11; s_urw = 2'b11; s_rw[0] = 2*c + 1; s_rw[1] = 2*c + 2;
         cycle();
      end
      reset_dut();

      // randomized traffic
      for (int cyc = 0; cyc < 3000; cyc++) begin
         clear_stim();
         for (int k = 0; k < RW; k++) begin
            s_valid[k] = ($urandom_range(0, 9) < 7);
            s_urs[k]   = $urandom_range(0, 1);
            s_urt[k]   = $urandom_range(0, 1);
            s_urw[k]   = ($urandom_range(0, 3) != 0);
            s_rs[k] = $urandom_range(0, 1) ? $urandom_range(0, 5) : $urandom_range(0, ARCH_REGS - 1);
            s_rt[k] = $urandom_range(0, 1) ? $urandom_range(0, 5) : $urandom_range(0, ARCH_REGS - 1);
            s_rw[k] = $urandom_range(0, 1) ? $urandom_range(0, 5) : $urandom_range(0, ARCH_REGS - 1);
         end
         lim = (rob_new.size() < RW) ? rob_new.size() : RW;
         nc  = (rob_new.size() > 24) ? lim : $urandom_range(0, lim);
         for (int k = 0; k < nc; k++) commit_rob_front(k, -1);
         if (nc < RW && $urandom_range(0, 7) == 0) begin
            c_valid[nc] = 1'b1; c_arch[nc] = 0; c_phys[nc] = 0; c_old[nc] = $urandom_range(1, PHYS_REGS - 1);
         end
         s_flush = ($urandom_range(0, 24) == 0);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
